md_unit_ctrl: RTL and testbench

//   Multi-cycle multiply/divide unit plus its pipeline scheduler for the 5-stage MIPS core.

---
 rtl/md_unit_ctrl.sv | 71 +++++++
 tb/tb_md_unit_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle mult/div unit with HI/LO registers and D-stage stall request
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_D,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        stall_req
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt;
    logic [31:0]   sh_hi, sh_lo;
    logic          sh_wr;
    logic          md_op, issue, sgn;
    logic [31:0]   dn, dd, q, r, qs, rs;
    logic [63:0]   res;

    assign md_op     = (op >= 3'd1) && (op <= 3'd4);
    assign busy      = cnt != '0;
    assign issue     = start && md_op && !busy;
    assign stall_req = md_use_D && (busy || (start && md_op));

    // Result datapath: signed division works on magnitudes so the 0x80000000/-1 case wraps cleanly
    always_comb begin
        sgn = op == 3'd3;
        dn  = (sgn && A[31]) ? -A : A;
        dd  = (sgn && B[31]) ? -B : B;
        q   = (B == '0) ? '0 : dn / dd;
        r   = (B == '0) ? '0 : dn % dd;
        qs  = (sgn && (A[31] ^ B[31])) ? -q : q;
        rs  = (sgn && A[31]) ? -r : r;
        res = (op == 3'd1) ? {{32{A[31]}}, A} * {{32{B[31]}}, B} :
              (op == 3'd2) ? {32'd0, A} * {32'd0, B} : {rs, qs};
    end

    // Latency counter, shadow result and HI/LO; start while busy falls into the countdown branch and is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            HI    <= '0;
            LO    <= '0;
            cnt   <= '0;
            sh_hi <= '0;
            sh_lo <= '0;
            sh_wr <= 1'b0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1) && sh_wr) begin
                HI <= sh_hi;
                LO <= sh_lo;
            end
        end else if (issue) begin
            cnt            <= (op <= 3'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            {sh_hi, sh_lo} <= res;
            sh_wr          <= !(op >= 3'd3 && B == '0);
        end else if (start && op == 3'd5) begin
            HI <= A;
        end else if (start && op == 3'd6) begin
            LO <= A;
        end
    end
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: randomized scoreboard bench for the mult/div unit
module tb_md_unit_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = '0, B = '0;
    logic        md_use_D = 1'b0;
    logic [31:0] HI, LO;
    logic        busy, stall_req;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb[$];
    logic [31:0] hi_m = '0, lo_m = '0;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .md_use_D(md_use_D), .HI(HI), .LO(LO), .busy(busy), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pop_cmp();
        logic [63:0] e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: result seen with no expected entry at %0t", $time);
        end else begin
            e = sb.pop_front();
            chk("HI", HI, e[63:32]);
            chk("LO", LO, e[31:0]);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        start = 1'b0;
        sb.delete();
        hi_m = '0;
        lo_m = '0;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic ud, input bit wait_done);
        longint sp, q, r;
        longint unsigned up;
        start = 1'b1; op = o; A = a; B = b; md_use_D = ud;
        case (o)
            3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); {hi_m, lo_m} = sp; end
            3'd2: begin up = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = up; end
            3'd3: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                lo_m = q[31:0];
                hi_m = r[31:0];
            end
            3'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
            3'd5: hi_m = a;
            3'd6: lo_m = a;
            default: ;
        endcase
        if (o != 3'd0 && o != 3'd7) sb.push_back({hi_m, lo_m});
        @(posedge clk);
        #1 start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
        if (wait_done && o >= 3'd1 && o <= 3'd4) begin
            repeat ((o <= 3'd2) ? 5 : 10) @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: timing model of busy/stall plus result pops at commit
    initial begin
        int left = 0;
        bit armed = 0;
        logic p_reset = 1'b1, p_start = 1'b0;
        logic [2:0] p_op = 3'd0;
        forever begin
            @(negedge clk);
            if (p_reset) begin
                left = 0;
                armed = 1;
            end else if (armed) begin
                if (left > 0) begin
                    left--;
                    if (left == 0) pop_cmp();
                end else if (p_start && p_op inside {[3'd1:3'd4]}) begin
                    left = (p_op <= 3'd2) ? 5 : 10;
                end else if (p_start && p_op inside {3'd5, 3'd6}) begin
                    pop_cmp();
                end
            end
            if (armed) begin
                chk("busy", 32'(busy), 32'(left != 0));
                chk("stall_req", 32'(stall_req),
                    32'(md_use_D && (left != 0 || (start && op inside {[3'd1:3'd4]}))));
            end
            p_reset = reset; p_start = start; p_op = op;
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired");
        $fatal(1, "timeout");
    end

    initial begin
        md_use_D = 1'b1;
        do_reset(2);
        @(negedge clk);
        chk("rst_HI", HI, 32'h0);
        chk("rst_LO", LO, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_stall", 32'(stall_req), 32'h0);
        @(posedge clk); #1;
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1);
        chk("mult_HI", HI, 32'hFFFF_FFFF);
        chk("mult_LO", LO, 32'hFFFF_FFFA);
        issue(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b1, 1);
        chk("multu_HI", HI, 32'h0000_0002);
        chk("multu_LO", LO, 32'hFFFF_FFFA);
        issue(3'd3, -32'd7, 32'd2, 1'b1, 1);
        chk("div_HI", HI, 32'hFFFF_FFFF);
        chk("div_LO", LO, 32'hFFFF_FFFD);
        issue(3'd4, 32'd7, 32'd0, 1'b0, 1);
        chk("divu0_HI", HI, 32'hFFFF_FFFF);
        chk("divu0_LO", LO, 32'hFFFF_FFFD);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1);
        chk("divov_HI", HI, 32'h0);
        chk("divov_LO", LO, 32'h8000_0000);
        issue(3'd5, 32'h1234_5678, 32'd0, 1'b1, 1);
        issue(3'd6, 32'h9ABC_DEF0, 32'd0, 1'b1, 1);
        chk("mthi_HI", HI, 32'h1234_5678);
        chk("mtlo_LO", LO, 32'h9ABC_DEF0);
        issue(3'd1, 32'd1000, 32'd77, 1'b1, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1; sb.delete(); hi_m = '0; lo_m = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_HI", HI, 32'h0);
        chk("abort_LO", LO, 32'h0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_nocommit_HI", HI, 32'h0);
        chk("abort_nocommit_LO", LO, 32'h0);
        for (int i = 0; i < 120; i++) begin
            issue(3'($urandom_range(0, 7)), rval(), rval(), 1'($urandom), 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1 chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
